// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a DEPTH-entry fetch queue.
//   Generates fetch PCs, drives the instruction SRAM (1-cycle read latency),
//   buffers returned instructions and hands them to ID over valid/ready.
//   Handles flush redirects, branch redirects that keep the MIPS delay slot
//   (including a delay slot that has not been fetched yet) and AdEL tagging
//   of misaligned fetch PCs.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   flush_i / flush_pc_i         pipeline flush and its redirect target
//   branch_en_i / branch_pc_i    taken branch resolved in ID and its target
//   inst_sram_*                  instruction SRAM request/response
//   dq_ready_i                   ID accepts the head entry
//   dq_valid_o, dq_pc_o, dq_inst_o, dq_inslot_o, dq_excs_o, dq_has_exc_o
//                                head entry of the fetch queue
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int unsigned EXC_W    = 8,
  parameter int unsigned ADEL_BIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [31:0]      flush_pc_i,
  input  logic             branch_en_i,
  input  logic [31:0]      branch_pc_i,
  output logic             inst_sram_en,
  output logic [31:0]      inst_sram_addr,
  output logic [3:0]       inst_sram_wen,
  output logic [31:0]      inst_sram_wdata,
  input  logic [31:0]      inst_sram_rdata,
  input  logic             dq_ready_i,
  output logic             dq_valid_o,
  output logic [31:0]      dq_pc_o,
  output logic [31:0]      dq_inst_o,
  output logic             dq_inslot_o,
  output logic [EXC_W-1:0] dq_excs_o,
  output logic             dq_has_exc_o
);

  localparam int unsigned    PW        = $clog2(DEPTH);
  localparam int unsigned    CW        = PW + 1;
  localparam logic [CW:0]    DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [EXC_W-1:0] ADEL_MASK = {{(EXC_W-1){1'b0}}, 1'b1} << ADEL_BIT;

  // Fetch PC, pending redirect and halt state
  logic [31:0]      r_fpc;
  logic             r_pend_redir;
  logic [31:0]      r_pend_pc;
  logic             r_halted;
  // In-flight request: its response is on inst_sram_rdata while r_if_valid=1
  logic             r_if_valid;
  logic [31:0]      r_if_pc;
  logic             r_if_discard;
  logic             r_if_ds;
  // Queue storage and bookkeeping
  logic [31:0]      r_q_pc     [DEPTH];
  logic [31:0]      r_q_inst   [DEPTH];
  logic             r_q_inslot [DEPTH];
  logic [EXC_W-1:0] r_q_excs   [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_head_v;
  logic [CW:0]      w_occ;
  logic             w_can;
  logic             w_issue;
  logic             w_if_live;
  logic             w_br;
  logic             w_br_head;
  logic             w_br_resp;
  logic             w_br_pend;
  logic             w_pend_eff;
  logic [31:0]      w_pend_pc_eff;
  logic             w_resp_push;
  logic             w_adel;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_push_pc;
  logic [31:0]      w_push_inst;
  logic             w_push_inslot;
  logic [EXC_W-1:0] w_push_excs;

  assign w_head_v  = (r_count != {CW{1'b0}});
  // Credit: every outstanding request already owns a queue slot
  assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_if_valid};
  assign w_can     = !flush_i && !r_halted && (w_occ < DEPTH_C);
  assign w_issue   = w_can && (r_fpc[1:0] == 2'b00);
  assign w_if_live = r_if_valid && !r_if_discard;
  assign w_pop     = w_head_v && dq_ready_i;

  // Branch classification: which instruction is the delay slot
  assign w_br      = branch_en_i && !flush_i;
  assign w_br_head = w_br && w_head_v;
  assign w_br_resp = w_br && !w_head_v && w_if_live;
  assign w_br_pend = w_br && !w_head_v && !w_if_live;

  // A branch with nothing fetched makes the next fetch the delay slot
  assign w_pend_eff    = r_pend_redir || w_br_pend;
  assign w_pend_pc_eff = w_br_pend ? branch_pc_i : r_pend_pc;

  assign w_resp_push = w_if_live && !flush_i && !w_br_head;
  // The AdEL entry waits for a live response so queue order follows fetch order
  assign w_adel      = w_can && (r_fpc[1:0] != 2'b00) && !w_if_live && !w_br_head;
  assign w_push      = w_resp_push || w_adel;

  assign w_push_pc     = w_adel ? r_fpc : r_if_pc;
  assign w_push_inst   = w_adel ? 32'h0 : inst_sram_rdata;
  assign w_push_inslot = w_adel ? w_pend_eff : (r_if_ds || w_br_resp);
  assign w_push_excs   = w_adel ? ADEL_MASK : {EXC_W{1'b0}};

  assign inst_sram_en    = rst_n && w_issue;
  assign inst_sram_addr  = r_fpc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign dq_valid_o   = w_head_v;
  assign dq_pc_o      = w_head_v ? r_q_pc[r_rd_ptr]   : 32'h0;
  assign dq_inst_o    = w_head_v ? r_q_inst[r_rd_ptr] : 32'h0;
  assign dq_inslot_o  = w_head_v && (r_q_inslot[r_rd_ptr] || w_br);
  assign dq_excs_o    = w_head_v ? r_q_excs[r_rd_ptr] : {EXC_W{1'b0}};
  assign dq_has_exc_o = |dq_excs_o;

  // Fetch PC, redirect, halt and in-flight tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc        <= RESET_PC;
      r_pend_redir <= 1'b0;
      r_pend_pc    <= 32'h0;
      r_halted     <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'h0;
      r_if_discard <= 1'b0;
      r_if_ds      <= 1'b0;
    end else begin
      r_if_valid   <= w_issue;
      r_if_pc      <= r_fpc;
      // A request issued while redirecting away is wrong-path
      r_if_discard <= w_br_head || w_br_resp;
      r_if_ds      <= w_pend_eff;
      if (flush_i) begin
        r_fpc        <= flush_pc_i;
        r_pend_redir <= 1'b0;
        r_halted     <= 1'b0;
      end else if (w_br_head || w_br_resp) begin
        r_fpc        <= branch_pc_i;
        r_pend_redir <= 1'b0;
      end else if (w_issue) begin
        r_fpc        <= w_pend_eff ? w_pend_pc_eff : r_fpc + 32'd4;
        r_pend_redir <= 1'b0;
      end else if (w_br_pend) begin
        r_pend_redir <= 1'b1;
        r_pend_pc    <= branch_pc_i;
      end else begin
        r_fpc <= r_fpc;
      end
      if (!flush_i && w_adel) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (flush_i) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (w_br_head) begin
      // Keep only the head (delay slot) unless ID takes it this cycle
      r_wr_ptr <= r_rd_ptr + PW'(1);
      r_rd_ptr <= w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
      r_count  <= w_pop ? {CW{1'b0}} : CW'(1);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage writes and delay-slot marking of a retained head
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]     <= w_push_pc;
      r_q_inst[r_wr_ptr]   <= w_push_inst;
      r_q_inslot[r_wr_ptr] <= w_push_inslot;
      r_q_excs[r_wr_ptr]   <= w_push_excs;
    end
    if (w_br_head && !w_pop) begin
      r_q_inslot[r_rd_ptr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios followed by
// random stimulus, each cycle compared against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          EXC_W    = 8;
  localparam int          ADEL_BIT = 1;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic [31:0]      flush_pc_i;
  logic             branch_en_i;
  logic [31:0]      branch_pc_i;
  logic             inst_sram_en;
  logic [31:0]      inst_sram_addr;
  logic [3:0]       inst_sram_wen;
  logic [31:0]      inst_sram_wdata;
  logic [31:0]      mem_rdata;
  logic             dq_ready_i;
  logic             dq_valid_o;
  logic [31:0]      dq_pc_o;
  logic [31:0]      dq_inst_o;
  logic             dq_inslot_o;
  logic [EXC_W-1:0] dq_excs_o;
  logic             dq_has_exc_o;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .EXC_W(EXC_W), .ADEL_BIT(ADEL_BIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .branch_en_i(branch_en_i), .branch_pc_i(branch_pc_i),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wen(inst_sram_wen), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(mem_rdata),
    .dq_ready_i(dq_ready_i), .dq_valid_o(dq_valid_o), .dq_pc_o(dq_pc_o),
    .dq_inst_o(dq_inst_o), .dq_inslot_o(dq_inslot_o), .dq_excs_o(dq_excs_o),
    .dq_has_exc_o(dq_has_exc_o)
  );

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h13579bdf;
  endfunction

  // Instruction memory: data one cycle after a request, junk otherwise
  always @(posedge clk) begin
    mem_rdata <= inst_sram_en ? sram_word(inst_sram_addr) : 32'hdeadbeef;
  end

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      inst;
    bit               inslot;
    logic [EXC_W-1:0] excs;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_fpc;
  bit          m_if_v, m_if_disc, m_if_ds;
  logic [31:0] m_if_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          m_halted;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc = RESET_PC; m_if_v = 0; m_if_disc = 0; m_if_ds = 0; m_if_pc = 32'h0;
    m_pend = 0; m_pend_pc = 32'h0; m_halted = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model
  task automatic run_cycle(input bit fl, input logic [31:0] fpc_t, input bit br,
                           input logic [31:0] bpc, input bit rdy);
    bit          head_v, aligned, can, issue, pop, live, brr, brp, pend_e, adel;
    logic [31:0] pend_pc_e;
    logic [EXC_W-1:0] adel_mask;
    ent_t        e;
    flush_i = fl; flush_pc_i = fpc_t; branch_en_i = br; branch_pc_i = bpc; dq_ready_i = rdy;
    @(negedge clk);
    head_v  = (m_q.size() != 0);
    aligned = (m_fpc[1:0] == 2'b00);
    can     = !fl && !m_halted && ((m_q.size() + int'(m_if_v)) < DEPTH);
    issue   = can && aligned;
    pop     = head_v && rdy;
    live    = m_if_v && !m_if_disc;
    check_val("sram_en", 32'(inst_sram_en), 32'(issue));
    if (issue) check_val("sram_addr", inst_sram_addr, m_fpc);
    check_val("sram_wen", 32'(inst_sram_wen), 32'h0);
    check_val("sram_wdata", inst_sram_wdata, 32'h0);
    check_val("dq_valid", 32'(dq_valid_o), 32'(head_v));
    if (head_v) begin
      check_val("dq_pc", dq_pc_o, m_q[0].pc);
      check_val("dq_inst", dq_inst_o, m_q[0].inst);
      check_val("dq_inslot", 32'(dq_inslot_o), 32'(m_q[0].inslot || (br && !fl)));
      check_val("dq_excs", 32'(dq_excs_o), 32'(m_q[0].excs));
      check_val("dq_has_exc", 32'(dq_has_exc_o), 32'(|m_q[0].excs));
    end
    // Advance reference model
    adel_mask = '0;
    adel_mask[ADEL_BIT] = 1'b1;
    if (fl) begin
      m_q.delete(); m_if_v = 0; m_pend = 0; m_halted = 0; m_fpc = fpc_t;
    end else if (br && head_v) begin
      e = m_q.pop_front();
      m_q.delete();
      if (!pop) begin
        e.inslot = 1;
        m_q.push_back(e);
      end
      m_if_v = issue; m_if_pc = m_fpc; m_if_disc = 1; m_if_ds = 0;
      m_fpc = bpc; m_pend = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      brr = br && live;
      brp = br && !live;
      if (live) begin
        e.pc = m_if_pc; e.inst = sram_word(m_if_pc); e.inslot = m_if_ds || brr; e.excs = '0;
        m_q.push_back(e);
      end
      pend_e    = m_pend || brp;
      pend_pc_e = brp ? bpc : m_pend_pc;
      adel      = can && !aligned && !live;
      if (adel) begin
        e.pc = m_fpc; e.inst = 32'h0; e.inslot = pend_e; e.excs = adel_mask;
        m_q.push_back(e);
        m_halted = 1;
      end
      m_if_pc = m_fpc; m_if_disc = brr; m_if_ds = issue && pend_e; m_if_v = issue;
      if (brr) begin
        m_fpc = bpc; m_pend = 0;
      end else if (issue) begin
        m_fpc = pend_e ? pend_pc_e : m_fpc + 32'd4;
        m_pend = 0;
      end else if (brp) begin
        m_pend = 1; m_pend_pc = bpc;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0; branch_en_i = 1'b0;
    branch_pc_i = 32'h0; dq_ready_i = 1'b1;
    // Outputs held quiet while in reset, whatever the inputs do
    for (int i = 0; i < 3; i++) begin
      branch_en_i = 1'b1; dq_ready_i = 1'b0;
      @(negedge clk);
      check_val("rst_sram_en", 32'(inst_sram_en), 32'h0);
      check_val("rst_dq_valid", 32'(dq_valid_o), 32'h0);
      check_val("rst_dq_pc", dq_pc_o, 32'h0);
      check_val("rst_dq_inst", dq_inst_o, 32'h0);
      check_val("rst_dq_inslot", 32'(dq_inslot_o), 32'h0);
      check_val("rst_dq_excs", 32'(dq_excs_o), 32'h0);
      check_val("rst_dq_has_exc", 32'(dq_has_exc_o), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Streaming from reset, then a ready stall that fills the queue
    idle(6, 1'b1);
    idle(10, 1'b0);
    idle(8, 1'b1);
    // Fill partially, then branch with entries queued (head becomes delay slot)
    idle(4, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b1, 32'h80001000, 1'b0);
    idle(6, 1'b1);
    // Flush with a response in flight
    run_cycle(1'b1, 32'hbfc00380, 1'b0, 32'h0, 1'b1);
    idle(5, 1'b1);
    // Flush, then branch with nothing fetched: delay slot fetched first
    run_cycle(1'b1, 32'h80002000, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b0, 32'h0, 1'b1, 32'h80003000, 1'b1);
    idle(5, 1'b1);
    // 32-bit fpc wrap-around
    run_cycle(1'b1, 32'hfffffff8, 1'b0, 32'h0, 1'b1);
    idle(6, 1'b1);
    // Branch to a misaligned target: AdEL entry, then fetch stays halted
    run_cycle(1'b0, 32'h0, 1'b1, 32'h80000002, 1'b1);
    idle(8, 1'b1);
    run_cycle(1'b1, RESET_PC, 1'b0, 32'h0, 1'b1);
    idle(4, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          fl, br, rdy;
      logic [31:0] fpc_t, bpc;
      fl    = ($urandom_range(0, 29) == 0);
      br    = ($urandom_range(0, 9) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      fpc_t = $urandom & 32'hfffffffc;
      bpc   = $urandom & 32'hfffffffc;
      if ($urandom_range(0, 7) == 0) bpc = bpc | 32'(($urandom_range(1, 3)));
      if ($urandom_range(0, 15) == 0) fpc_t = fpc_t | 32'h2;
      run_cycle(fl, fpc_t, br, bpc, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
